fifo_umbral: RTL and testbench

//  Synchronous FIFO with programmable almost-full/almost-empty thresholds for the PCIe transaction layer.

---
 rtl/fifo_umbral.sv | 79 +++++++
 tb/tb_fifo_umbral.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] umbral_superior,
    input  logic [ADDR_WIDTH-1:0] umbral_inferior,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  error_q, error_d;
    logic                  push_ok, pop_ok;

    assign count        = count_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign error        = error_q;
    assign empty        = count_q == '0;
    assign full         = count_q == FULL_CNT;
    assign almost_full  = (umbral_superior != '0) && (count_q >= {1'b0, umbral_superior});
    assign almost_empty = count_q <= {1'b0, umbral_inferior};

    // Acceptance rules: no fall-through on empty, simultaneous push/pop allowed when full
    always_comb begin
        pop_ok       = pop && !empty;
        push_ok      = push && (!full || pop_ok);
        wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = (push_ok && !pop_ok) ? count_q + 1'b1 :
                       (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
        data_out_d   = pop_ok ? mem_q[rd_ptr_q] : data_out_q;
        data_valid_d = pop_ok;
        error_d      = error_q || (push && full && !pop) || (pop && empty);
    end

    // Control state; reset discards contents and clears the sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    // Storage is never cleared; stale words are unreachable while empty
    always_ff @(posedge clk) begin
        if (push_ok && !reset)
            mem_q[wr_ptr_q] <= data_in;
    end
endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: table-driven and directed checks of fifo_umbral
module tb_fifo_umbral;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] umbral_superior = 3'd6;
    logic [2:0] umbral_inferior = 3'd2;
    logic       push = 1'b0;
    logic [5:0] data_in = '0;
    logic       pop = 1'b0;
    logic [5:0] data_out;
    logic       data_valid;
    logic [3:0] count;
    logic       empty, full, almost_full, almost_empty, error;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int push; int pop; int din;
        int cnt; int e; int f; int af; int ae; int dv; int dout; int err;
    } vec_t;
    vec_t tbl[18];

    fifo_umbral dut (
        .clk(clk), .reset(reset),
        .umbral_superior(umbral_superior), .umbral_inferior(umbral_inferior),
        .push(push), .data_in(data_in), .pop(pop),
        .data_out(data_out), .data_valid(data_valid), .count(count),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int cnt, input int e, input int f,
                             input int af, input int ae, input int dv, input int dout, input int err);
        chk({tag, " count"}, int'(count), cnt);
        chk({tag, " empty"}, int'(empty), e);
        chk({tag, " full"}, int'(full), f);
        chk({tag, " almost_full"}, int'(almost_full), af);
        chk({tag, " almost_empty"}, int'(almost_empty), ae);
        chk({tag, " data_valid"}, int'(data_valid), dv);
        chk({tag, " data_out"}, int'(data_out), dout);
        chk({tag, " error"}, int'(error), err);
    endtask

    task automatic step(input logic p, input logic q, input logic [5:0] d);
        push = p;
        pop = q;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 6'h00);
        reset = 1'b0;
    endtask

    initial begin
        //          push pop din   cnt e f af ae dv dout  err
        tbl[0]  = '{1, 0, 'h01,  1, 0, 0, 0, 1, 0, 'h00, 0};
        tbl[1]  = '{1, 0, 'h02,  2, 0, 0, 0, 1, 0, 'h00, 0};
        tbl[2]  = '{1, 0, 'h03,  3, 0, 0, 0, 0, 0, 'h00, 0};
        tbl[3]  = '{1, 0, 'h04,  4, 0, 0, 0, 0, 0, 'h00, 0};
        tbl[4]  = '{1, 0, 'h05,  5, 0, 0, 0, 0, 0, 'h00, 0};
        tbl[5]  = '{1, 0, 'h06,  6, 0, 0, 1, 0, 0, 'h00, 0};
        tbl[6]  = '{1, 0, 'h07,  7, 0, 0, 1, 0, 0, 'h00, 0};
        tbl[7]  = '{1, 0, 'h08,  8, 0, 1, 1, 0, 0, 'h00, 0};
        tbl[8]  = '{1, 0, 'h3F,  8, 0, 1, 1, 0, 0, 'h00, 1};
        tbl[9]  = '{0, 1, 'h00,  7, 0, 0, 1, 0, 1, 'h01, 1};
        tbl[10] = '{0, 1, 'h00,  6, 0, 0, 1, 0, 1, 'h02, 1};
        tbl[11] = '{0, 1, 'h00,  5, 0, 0, 0, 0, 1, 'h03, 1};
        tbl[12] = '{0, 1, 'h00,  4, 0, 0, 0, 0, 1, 'h04, 1};
        tbl[13] = '{0, 1, 'h00,  3, 0, 0, 0, 0, 1, 'h05, 1};
        tbl[14] = '{0, 1, 'h00,  2, 0, 0, 0, 1, 1, 'h06, 1};
        tbl[15] = '{0, 1, 'h00,  1, 0, 0, 0, 1, 1, 'h07, 1};
        tbl[16] = '{0, 1, 'h00,  0, 1, 0, 0, 1, 1, 'h08, 1};
        tbl[17] = '{0, 0, 'h00,  0, 1, 0, 0, 1, 0, 'h08, 1};

        do_reset();
        step(1'b0, 1'b0, 6'h00);
        chk_state("idle", 0, 1, 0, 0, 1, 0, 'h00, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].push[0], tbl[i].pop[0], 6'(tbl[i].din));
            chk_state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].e, tbl[i].f, tbl[i].af,
                      tbl[i].ae, tbl[i].dv, tbl[i].dout, tbl[i].err);
        end

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'(8'h10 + i));
        chk_state("wrap full", 8, 0, 1, 1, 0, 0, 'h00, 0);
        step(1'b1, 1'b1, 6'h2A);
        chk_state("wrap swap", 8, 0, 1, 1, 0, 1, 'h10, 0);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 6'h00);
            chk($sformatf("wrap pop%0d data_out", i), int'(data_out), 'h10 + i);
        end
        step(1'b0, 1'b1, 6'h00);
        chk_state("wrap last", 0, 1, 0, 0, 1, 1, 'h2A, 0);

        step(1'b1, 1'b1, 6'h15);
        chk_state("empty push+pop", 1, 0, 0, 0, 1, 0, 'h2A, 1);
        step(1'b0, 1'b1, 6'h00);
        chk_state("empty follow pop", 0, 1, 0, 0, 1, 1, 'h15, 1);

        do_reset();
        step(1'b0, 1'b1, 6'h00);
        chk("underflow error", int'(error), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(8'h20 + i));
        chk("pre-reset count", int'(count), 5);
        umbral_superior = 3'd5;
        #1 chk("af at sup=count", int'(almost_full), 1);
        umbral_superior = 3'd0;
        #1 chk("af forced off at sup=0", int'(almost_full), 0);
        umbral_inferior = 3'd5;
        #1 chk("ae at inf=count", int'(almost_empty), 1);
        umbral_inferior = 3'd4;
        #1 chk("ae off at inf<count", int'(almost_empty), 0);
        umbral_superior = 3'd6;
        umbral_inferior = 3'd2;
        reset = 1'b1;
        step(1'b1, 1'b1, 6'h33);
        reset = 1'b0;
        chk_state("reset mid-op", 0, 1, 0, 0, 1, 0, 'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
